// File: rtl/minicpu_data_sram_resp.sv
// minicpu_data_sram_resp: CPU data-port responder with word RAM, console TX FIFO, status and cycle counter.
// Define DRAM_CLEAR_EN to zero the RAM after reset (init_done low during the sweep).
module minicpu_data_sram_resp #(
   parameter int unsigned ADDR_W     = 10,
   parameter logic [31:0] RAM_BASE   = 32'h1c000000,
   parameter logic [31:0] MMIO_BASE  = 32'hbfaff000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        init_done,
   output logic        err_sticky
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   logic [31:0]       mem [2**ADDR_W];
   logic [7:0]        fifo [FIFO_DEPTH];
   logic [ADDR_W-1:0] idx, mem_idx;
   logic [31:0]       mem_wd, stat, cyc_q, cyc_d;
   logic [11:0]       off;
   logic [PW-1:0]     rd_q, wr_q;
   logic [PW:0]       cnt_q, cnt_d;
   logic              ram_hit, mmio_hit, aligned, run, wr_ok, ram_we, mem_we;
   logic              push, pop, push_ok, full, empty, cyc_wr, err_q, err_d;

   assign idx      = data_sram_addr[ADDR_W+1:2];
   assign off      = data_sram_addr[11:0];
   assign ram_hit  = data_sram_addr[31:ADDR_W+2] == RAM_BASE[31:ADDR_W+2];
   assign mmio_hit = data_sram_addr[31:12] == MMIO_BASE[31:12];
   assign aligned  = data_sram_addr[1:0] == 2'b00;
   assign wr_ok    = data_sram_we & run & aligned;
   assign ram_we   = wr_ok & ram_hit;
   assign push     = wr_ok & mmio_hit & (off == 12'h000);
   assign cyc_wr   = wr_ok & mmio_hit & (off == 12'h008);

`ifdef DRAM_CLEAR_EN
   typedef enum logic {CLEAR, RUN} state_t;
   state_t            state_q;
   logic [ADDR_W-1:0] clr_q;
   logic              init_q;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= CLEAR;
         clr_q   <= '0;
         init_q  <= 1'b0;
      end else if (state_q == CLEAR) begin
         clr_q <= clr_q + 1'b1;
         if (&clr_q) begin
            state_q <= RUN;
            init_q  <= 1'b1;
         end
      end
   end
   assign run       = state_q == RUN;
   assign init_done = init_q;
   assign mem_we    = !run | ram_we;
   assign mem_idx   = run ? idx : clr_q;
   assign mem_wd    = run ? data_sram_wdata : 32'h0;
`else
   assign run       = 1'b1;
   assign init_done = 1'b1;
   assign mem_we    = ram_we;
   assign mem_idx   = idx;
   assign mem_wd    = data_sram_wdata;
`endif

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_idx] <= mem_wd;
   end

   assign empty   = cnt_q == '0;
   assign full    = cnt_q == (PW+1)'(FIFO_DEPTH);
   assign pop     = !empty & tx_ready;
   assign push_ok = push & (!full | pop);
   assign stat    = {16'b0, 8'(cnt_q), 6'b0, full, empty};

   always_ff @(posedge clk) begin
      if (push_ok) fifo[wr_q] <= data_sram_wdata[7:0];
   end

   // Bad alignment or no decode hit is an error only while the CPU is allowed to write.
   always_comb begin
      cnt_d = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
      cyc_d = cyc_wr ? data_sram_wdata : cyc_q + 32'd1;
      err_d = err_q | (data_sram_we & run & (!aligned | !(ram_hit | mmio_hit))) | (push & full & !pop);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         cyc_q <= '0;
         err_q <= 1'b0;
      end else begin
         rd_q  <= rd_q + PW'(pop);
         wr_q  <= wr_q + PW'(push_ok);
         cnt_q <= cnt_d;
         cyc_q <= cyc_d;
         err_q <= err_d;
      end
   end

   assign data_sram_rdata = ram_hit                        ? (run ? mem[idx] : 32'h0) :
                            (mmio_hit && off == 12'h004)   ? stat :
                            (mmio_hit && off == 12'h008)   ? cyc_q : 32'h0;
   assign tx_valid   = !empty;
   assign tx_data    = fifo[rd_q];
   assign err_sticky = err_q;
endmodule

// File: tb/tb_minicpu_data_sram_resp.sv
// tb_minicpu_data_sram_resp: directed checks of RAM, console FIFO, status, cycle counter and errors.
module tb_minicpu_data_sram_resp;
   localparam logic [31:0] RB   = 32'h1c000000;
   localparam logic [31:0] MB   = 32'hbfaff000;
   localparam logic [31:0] CONS = MB;
   localparam logic [31:0] STAT = MB + 32'h4;
   localparam logic [31:0] CYC  = MB + 32'h8;

   logic        clk = 1'b0, resetn = 1'b0, we = 1'b0, tx_ready = 1'b0;
   logic [31:0] addr = '0, wdata = '0, rdata, v;
   logic        tx_valid, init_done, err_sticky;
   logic [7:0]  tx_data;
   int          checks = 0, failures = 0, n;

   always #5 clk = ~clk;

   minicpu_data_sram_resp #(.ADDR_W(4), .RAM_BASE(RB), .MMIO_BASE(MB), .FIFO_DEPTH(8)) dut (
      .clk(clk), .resetn(resetn), .data_sram_we(we), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .data_sram_rdata(rdata), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready), .init_done(init_done), .err_sticky(err_sticky)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      we   = 1'b0;
      #1 d = rdata;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic wait_init();
      for (int i = 0; i < 100 && !init_done; i++) @(negedge clk);
      chk("init_done", 32'(init_done), 32'h1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn   = 1'b0;
      we       = 1'b0;
      tx_ready = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      wait_init();
   endtask

   task automatic count_sweep(output int cnt);
      cnt = 0;
      while (!init_done && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst_err", 32'(err_sticky), 32'h0);
      rd(STAT, v); chk("rst_stat", v, 32'h1);
      rd(CYC, v);  chk("rst_cycle", v, 32'h0);
`ifdef DRAM_CLEAR_EN
      chk("rst_init", 32'(init_done), 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      rd(RB + 32'h4, v); chk("clr_rd0", v, 32'h0);
      count_sweep(n);
      chk("sweep_len", 32'(n), 32'd16);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      #1 chk("mid_rst_init", 32'(init_done), 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      count_sweep(n);
      chk("resweep_len", 32'(n), 32'd16);
      for (int i = 0; i < 16; i++) begin
         rd(RB + 32'(4 * i), v);
         chk("clr_word", v, 32'h0);
      end
`else
      chk("rst_init", 32'(init_done), 32'h1);
      @(negedge clk);
      resetn = 1'b1;
      rd(CYC, v); chk("cycle_rel", v, 32'h0);
      @(negedge clk);
      rd(CYC, v); chk("cycle_inc", v, 32'h1);
`endif
      wait_init();

      wr(RB + 32'h10, 32'hdeadbeef);
      rd(RB + 32'h10, v); chk("t1_rd", v, 32'hdeadbeef);
      wr(RB + 32'h20, 32'h11111111);
      addr = RB + 32'h20; wdata = 32'h22222222; we = 1'b1;
      #1 chk("t1_same_cyc", rdata, 32'h11111111);
      @(negedge clk);
      rd(RB + 32'h20, v); chk("t1_next_cyc", v, 32'h22222222);
      rd(CONS, v); chk("cons_rd", v, 32'h0);

      wr(CONS, 32'h41); wr(CONS, 32'h42); wr(CONS, 32'h43);
      rd(STAT, v); chk("t2_stat3", v, 32'h00000300);
      chk("t2_valid", 32'(tx_valid), 32'h1);
      tx_ready = 1'b1;
      chk("t2_d0", 32'(tx_data), 32'h41);
      @(negedge clk); chk("t2_d1", 32'(tx_data), 32'h42);
      @(negedge clk); chk("t2_d2", 32'(tx_data), 32'h43);
      @(negedge clk); tx_ready = 1'b0;
      rd(STAT, v); chk("t2_stat_empty", v, 32'h00000001);
      chk("t2_valid0", 32'(tx_valid), 32'h0);

      for (int i = 0; i < 8; i++) wr(CONS, 32'h50 + 32'(i));
      rd(STAT, v); chk("t3_full", v, 32'h00000802);
      chk("t3_err0", 32'(err_sticky), 32'h0);
      wr(CONS, 32'h99);
      chk("t3_err1", 32'(err_sticky), 32'h1);
      rd(STAT, v); chk("t3_still8", v, 32'h00000802);
      tx_ready = 1'b1;
      wr(CONS, 32'haa);
      tx_ready = 1'b0;
      rd(STAT, v); chk("t3_pp_cnt", v, 32'h00000802);
      chk("t3_head", 32'(tx_data), 32'h51);
      tx_ready = 1'b1;
      repeat (7) @(negedge clk);
      chk("t3_tail", 32'(tx_data), 32'haa);
      @(negedge clk); tx_ready = 1'b0;
      rd(STAT, v); chk("t3_drained", v, 32'h00000001);

      wr(CYC, 32'hfffffffe);
      rd(CYC, v); chk("t4_load", v, 32'hfffffffe);
      @(negedge clk); rd(CYC, v); chk("t4_1clk", v, 32'hffffffff);
      @(negedge clk); rd(CYC, v); chk("t4_wrap", v, 32'h0);

      do_reset();
      chk("t5_err_rst", 32'(err_sticky), 32'h0);
      rd(32'h0, v); chk("t5_unmapped_rd", v, 32'h0);
      chk("t5_rd_no_err", 32'(err_sticky), 32'h0);
      wr(32'h0, 32'h12345678);
      chk("t5_unmapped_err", 32'(err_sticky), 32'h1);
      do_reset();
      wr(RB, 32'hcafef00d);
      chk("t5_err_clean", 32'(err_sticky), 32'h0);
      wr(RB + 32'h2, 32'h00000bad);
      rd(RB, v); chk("t5_misalign_ram", v, 32'hcafef00d);
      chk("t5_misalign_err", 32'(err_sticky), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
